// File: rtl/tdm_demultiplexer_if.sv
// rtl/tdm_demultiplexer_if.sv - sample stream and per-channel output bundle for the TDM demultiplexer
interface tdm_demultiplexer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             frame_sync;
  logic             clear_error;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic             addr0;
  logic             addr1;
  logic             frame_valid;
  logic             sync_error;

  // Upstream side: drives samples, observes demultiplexed channels
  modport master (
    output in_valid, in_data, frame_sync, clear_error,
    input  out0, out1, out2, out3, addr0, addr1, frame_valid, sync_error
  );

  // Demultiplexer side
  modport slave (
    input  in_valid, in_data, frame_sync, clear_error,
    output out0, out1, out2, out3, addr0, addr1, frame_valid, sync_error
  );
endinterface

// File: rtl/tdm_demultiplexer.sv
// rtl/tdm_demultiplexer.sv - 4-slot TDM demultiplexer with frame sync tracking and double-buffered outputs
module tdm_demultiplexer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  tdm_demultiplexer_if.slave   bus
);

  typedef enum logic {
    HUNT,
    RUN
  } state_t;

  state_t           state;
  logic [1:0]       slot;
  logic [WIDTH-1:0] shadow0;
  logic [WIDTH-1:0] shadow1;
  logic [WIDTH-1:0] shadow2;

  // Slot tracking, shadow capture and whole-frame output update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= HUNT;
      slot            <= 2'd0;
      shadow0         <= '0;
      shadow1         <= '0;
      shadow2         <= '0;
      bus.out0        <= '0;
      bus.out1        <= '0;
      bus.out2        <= '0;
      bus.out3        <= '0;
      bus.addr0       <= 1'b0;
      bus.addr1       <= 1'b0;
      bus.frame_valid <= 1'b0;
      bus.sync_error  <= 1'b0;
    end else begin
      bus.frame_valid <= 1'b0;
      // Clear first so that an error event later in this block wins
      if (bus.clear_error) begin
        bus.sync_error <= 1'b0;
      end
      if (bus.in_valid) begin
        case (state)
          HUNT: begin
            // Anything other than a sync-marked sample is dropped silently
            if (bus.frame_sync) begin
              shadow0   <= bus.in_data;
              slot      <= 2'd1;
              bus.addr0 <= 1'b0;
              bus.addr1 <= 1'b0;
              state     <= RUN;
            end
          end
          default: begin
            if (slot == 2'd0) begin
              if (bus.frame_sync) begin
                shadow0   <= bus.in_data;
                slot      <= 2'd1;
                bus.addr0 <= 1'b0;
                bus.addr1 <= 1'b0;
              end else begin
                // Lost alignment: sync expected but absent
                bus.sync_error <= 1'b1;
                state          <= HUNT;
              end
            end else if (bus.frame_sync) begin
              // Early sync: drop the partial frame and restart on this sample
              bus.sync_error <= 1'b1;
              shadow0        <= bus.in_data;
              slot           <= 2'd1;
              bus.addr0      <= 1'b0;
              bus.addr1      <= 1'b0;
            end else begin
              bus.addr0 <= slot[0];
              bus.addr1 <= slot[1];
              case (slot)
                2'd1: begin
                  shadow1 <= bus.in_data;
                  slot    <= 2'd2;
                end
                2'd2: begin
                  shadow2 <= bus.in_data;
                  slot    <= 2'd3;
                end
                default: begin
                  // Last slot goes straight to out3; no shadow needed
                  bus.out0        <= shadow0;
                  bus.out1        <= shadow1;
                  bus.out2        <= shadow2;
                  bus.out3        <= bus.in_data;
                  bus.frame_valid <= 1'b1;
                  slot            <= 2'd0;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// tb/tb_tdm_demultiplexer.sv - scoreboard bench for the TDM demultiplexer
module tb_tdm_demultiplexer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   fv_count;
  int   fv_cycles[$];
  logic [31:0] exp_q[$];

  tdm_demultiplexer_if #(.WIDTH(8)) bus ();

  tdm_demultiplexer #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every completed frame against the scoreboard head
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) begin
      fv_count++;
      fv_cycles.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_frame", {bus.out0, bus.out1, bus.out2, bus.out3}, 32'hxxxx_xxxx);
      end else begin
        check("frame", {bus.out0, bus.out1, bus.out2, bus.out3}, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [7:0] d, input logic s, input logic clr);
    bus.in_valid    = 1'b1;
    bus.in_data     = d;
    bus.frame_sync  = s;
    bus.clear_error = clr;
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b0;
    bus.frame_sync  = 1'b0;
    bus.clear_error = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid    = 1'b0;
    bus.frame_sync  = 1'b0;
    bus.clear_error = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic frame(input logic [31:0] v);
    drive(v[31:24], 1'b1, 1'b0);
    drive(v[23:16], 1'b0, 1'b0);
    drive(v[15:8],  1'b0, 1'b0);
    exp_q.push_back(v);
    drive(v[7:0],   1'b0, 1'b0);
  endtask

  initial begin
    int fv_before;
    cyc             = 0;
    checks          = 0;
    errors          = 0;
    fv_count        = 0;
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    bus.frame_sync  = 1'b0;
    bus.clear_error = 1'b0;
    reset           = 1'b1;
    #12;
    check("rst_outs", {bus.out0, bus.out1, bus.out2, bus.out3}, 32'h0);
    check("rst_addr", {30'd0, bus.addr1, bus.addr0}, 32'd0);
    check("rst_fv", {31'd0, bus.frame_valid}, 32'd0);
    check("rst_err", {31'd0, bus.sync_error}, 32'd0);
    reset = 1'b0;
    idle(1);

    // Single frame
    frame(32'hA1B2C3D4);
    check("t1_addr", {30'd0, bus.addr1, bus.addr0}, 32'd3);
    check("t1_err", {31'd0, bus.sync_error}, 32'd0);
    idle(2);
    check("t1_fv_once", fv_count, 1);

    // Frame with two idle cycles between samples
    do_reset();
    drive(8'hA1, 1'b1, 1'b0);
    idle(2);
    check("t2_hold0", {bus.out0, bus.out1, bus.out2, bus.out3}, 32'h0);
    drive(8'hB2, 1'b0, 1'b0);
    idle(2);
    check("t2_addr1", {30'd0, bus.addr1, bus.addr0}, 32'd1);
    drive(8'hC3, 1'b0, 1'b0);
    idle(2);
    check("t2_hold2", {bus.out0, bus.out1, bus.out2, bus.out3}, 32'h0);
    exp_q.push_back(32'hA1B2C3D4);
    drive(8'hD4, 1'b0, 1'b0);
    idle(3);
    check("t2_fv_once", fv_count, 2);

    // Back-to-back frames
    fv_cycles.delete();
    frame(32'h11223344);
    frame(32'h55667788);
    idle(2);
    check("t3_fv_count", fv_count, 4);
    if (fv_cycles.size() == 2)
      check("t3_spacing", fv_cycles[1] - fv_cycles[0], 4);
    else
      check("t3_pulses", fv_cycles.size(), 2);
    check("t3_final", {bus.out0, bus.out1, bus.out2, bus.out3}, 32'h55667788);

    // Early sync at slot 2
    do_reset();
    drive(8'h01, 1'b1, 1'b0);
    drive(8'h02, 1'b0, 1'b0);
    drive(8'h09, 1'b1, 1'b0);
    check("t4_err", {31'd0, bus.sync_error}, 32'd1);
    check("t4_addr", {30'd0, bus.addr1, bus.addr0}, 32'd0);
    drive(8'h0A, 1'b0, 1'b0);
    drive(8'h0B, 1'b0, 1'b0);
    exp_q.push_back(32'h090A0B0C);
    drive(8'h0C, 1'b0, 1'b0);
    idle(2);

    // Clear alone
    bus.clear_error = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_error = 1'b0;
    check("t5_clear", {31'd0, bus.sync_error}, 32'd0);

    // Missing sync at slot 0
    frame(32'h11223344);
    drive(8'hEE, 1'b0, 1'b0);
    check("t5_err", {31'd0, bus.sync_error}, 32'd1);
    check("t5_addr_keep", {30'd0, bus.addr1, bus.addr0}, 32'd3);
    drive(8'h5A, 1'b0, 1'b0);
    drive(8'h5B, 1'b0, 1'b0);
    drive(8'h5C, 1'b0, 1'b0);
    drive(8'h5D, 1'b0, 1'b0);
    idle(1);
    check("t5_hunt_discard", {bus.out0, bus.out1, bus.out2, bus.out3}, 32'h11223344);
    frame(32'hC0C1C2C3);
    idle(1);

    // Clear coincident with early sync: set wins
    bus.clear_error = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_error = 1'b0;
    check("t6_pre_clear", {31'd0, bus.sync_error}, 32'd0);
    drive(8'h01, 1'b1, 1'b0);
    drive(8'h02, 1'b0, 1'b0);
    drive(8'h0D, 1'b1, 1'b1);
    check("t6_set_wins", {31'd0, bus.sync_error}, 32'd1);
    drive(8'h0E, 1'b0, 1'b0);
    drive(8'h0F, 1'b0, 1'b0);
    exp_q.push_back(32'h0D0E0F10);
    drive(8'h10, 1'b0, 1'b0);
    idle(1);

    // Asynchronous reset mid-frame
    frame(32'h21222324);
    drive(8'h31, 1'b1, 1'b0);
    drive(8'h32, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("t7_rst_outs", {bus.out0, bus.out1, bus.out2, bus.out3}, 32'h0);
    check("t7_rst_addr", {30'd0, bus.addr1, bus.addr0}, 32'd0);
    check("t7_rst_err", {31'd0, bus.sync_error}, 32'd0);
    #2;
    reset = 1'b0;
    fv_before = fv_count;
    drive(8'h33, 1'b0, 1'b0);
    drive(8'h34, 1'b0, 1'b0);
    drive(8'h35, 1'b0, 1'b0);
    idle(1);
    check("t7_ignored_addr", {30'd0, bus.addr1, bus.addr0}, 32'd0);
    check("t7_no_frame", fv_count, fv_before);
    frame(32'h41424344);
    idle(2);
    check("t7_final", {bus.out0, bus.out1, bus.out2, bus.out3}, 32'h41424344);

    check("total_frames", fv_count, 10);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
